regfile_dump_ctrl: RTL and testbench
====================================

REGFILE_DUMP_CTRL -- requirements
Module: regfile_dump_ctrl

Interface
REQ-001 Parameter WIDTH SHALL be: default 32, register word width, multiple of 8.
REQ-002 Port clk SHALL be: input, 1, single clock; all state on rising edge.
REQ-003 Port reset SHALL be: input, 1, asynchronous, active-low reset.
REQ-004 Port start SHALL be: input, 1, dump request, sampled only in IDLE.
REQ-005 Port first_reg SHALL be: input, 5, first register index, sampled on accepted start.
REQ-006 Port last_reg SHALL be: input, 5, last register index, sampled on accepted start.
REQ-007 Port abort SHALL be: input, 1, cancels a dump in progress.
REQ-008 Port dbg_sel SHALL be: output, 5, drives the register file debug read-select.
REQ-009 Port dbg_data SHALL be: input, WIDTH, register file debug read data, combinational from dbg_sel.
REQ-010 Port tx_data SHALL be: output, 8, byte to the UART transmitter.
REQ-011 Port tx_valid SHALL be: output, 1, tx_data is valid.
REQ-012 Port tx_ready SHALL be: input, 1, transmitter accepts the byte.
REQ-013 Port busy SHALL be: output, 1, high in every state except IDLE.
REQ-014 Port done SHALL be: output, 1, one-cycle pulse when a dump completes normally.

Function
REQ-015 The FSM SHALL have the states IDLE, CAPTURE, SEND_IDX, SEND_DATA and DONE.
REQ-016 IDLE SHALL move to CAPTURE when start=1; this latches first_reg/last_reg and sets cur=first_reg.
REQ-017 CAPTURE SHALL last exactly 1 cycle: dbg_sel=cur, dbg_data latched into the word buffer at the clock edge, next state SEND_IDX.
REQ-018 dbg_sel SHALL equal cur in every non-IDLE state and hold its last value in IDLE.
REQ-019 SEND_IDX SHALL drive tx_data={3'b000,cur} with tx_valid=1, moving to SEND_DATA when tx_valid&tx_ready.
REQ-020 SEND_DATA SHALL send WIDTH/8 bytes from the word buffer, MSB byte first, advancing one byte per tx_valid&tx_ready.
REQ-021 After the last byte, if cur==last_reg the FSM SHALL go to DONE; otherwise cur=cur+1 mod 32 and the FSM SHALL go to CAPTURE.
REQ-022 When first_reg>last_reg, cur SHALL wrap from 31 to 0; when first_reg==last_reg, exactly one register SHALL be dumped.
REQ-023 DONE SHALL assert done for 1 cycle and then return to IDLE; tx_valid=0 in DONE.
REQ-024 While tx_valid=1 and tx_ready=0, tx_data SHALL be held stable.
REQ-025 tx_valid SHALL be 0 in IDLE, CAPTURE and DONE.
REQ-026 Each register's transmitted word SHALL be its value in its CAPTURE cycle; later register-file writes SHALL NOT alter it.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE at the next edge, drop tx_valid in that same next cycle, and leave done unasserted; abort has priority over a simultaneous transfer.
REQ-029 With tx_ready held at 1, a register SHALL take 2+WIDTH/8 cycles; for WIDTH=32, the index byte appears 2 cycles after start.

Reset
REQ-030 reset=0 SHALL asynchronously force: state IDLE, dbg_sel=0, tx_data=0, tx_valid=0, busy=0, done=0, cur=0, byte counter=0, word buffer=0.
REQ-031 reset asserted mid-dump SHALL discard the dump with no done pulse; after release, the block SHALL wait for a new start.

Structure
REQ-032 Package regfile_dump_pkg SHALL hold the state enumeration, the 5-bit register-index width, and the function BYTES_PER_WORD(WIDTH) with its counter width.
REQ-033 The word-buffer/byte-select logic SHALL be one sub-module, word_byte_serializer (load, advance, byte_out, last_byte).
REQ-034 The register file SHALL NOT be instantiated inside this block; connection is via dbg_sel/dbg_data only.

Verification
REQ-035 x1=0x12345678, first=last=1, tx_ready=1, start -> bytes 01,12,34,56,78 on consecutive cycles, then done pulse, busy low.
REQ-036 first=30, last=1 -> index order 1E,1F,00,01 with register 0 data 00000000; 20 bytes total.
REQ-037 tx_ready toggled 1-of-3 cycles -> tx_data stable while stalled; byte sequence identical to the stall-free run.
REQ-038 x5 written to 0xFFFFFFFF one cycle after CAPTURE of x5 (old value 0x0000000A) -> bytes 05,00,00,00,0A.
REQ-039 abort during the 2nd data byte -> tx_valid=0 next cycle, no done, busy=0; a new start dumps correctly.
REQ-040 reset pulsed low mid-dump, and start pulsed while busy -> outputs at reset values; the ignored start produces no extra bytes.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
`default_nettype none
// regfile_dump_pkg: shared types and sizing helpers for the register-file dump controller.
// Rev 1.0
package regfile_dump_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CAPTURE   = 3'd1,
    ST_SEND_IDX  = 3'd2,
    ST_SEND_DATA = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  function automatic int BYTES_PER_WORD(input int width);
    return width / 8;
  endfunction

  function automatic int BYTE_CNT_W(input int width);
    return (width / 8 > 1) ? $clog2(width / 8) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/word_byte_serializer.sv
`default_nettype none
// word_byte_serializer: snapshots one register word and presents it MSB byte first.
// Rev 1.0
module word_byte_serializer
  import regfile_dump_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             advance,
  output logic [7:0]       byte_out,
  output logic             last_byte
);

  localparam int NBYTES = BYTES_PER_WORD(WIDTH);
  localparam int CW     = BYTE_CNT_W(WIDTH);

  logic [WIDTH-1:0] word_q;
  logic [CW-1:0]    cnt;
  logic [7:0]       bytes [NBYTES];

  // The snapshot is taken only on load, so later register-file writes cannot leak in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      cnt    <= '0;
    end else if (load) begin
      word_q <= load_data;
      cnt    <= '0;
    end else if (advance) begin
      cnt <= last_byte ? '0 : cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NBYTES; i++) begin : g_bytes
    assign bytes[i] = word_q[WIDTH-1-8*i -: 8];
  end

  assign byte_out  = bytes[cnt];
  assign last_byte = (cnt == CW'(NBYTES - 1));

endmodule
`default_nettype wire

// File: rtl/regfile_dump_ctrl.sv
`default_nettype none
// regfile_dump_ctrl: streams a range of register indices and values out as UART bytes.
// Rev 1.0
module regfile_dump_ctrl
  import regfile_dump_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [REG_IDX_W-1:0] first_reg,
  input  logic [REG_IDX_W-1:0] last_reg,
  input  logic                 abort,
  output logic [REG_IDX_W-1:0] dbg_sel,
  input  logic [WIDTH-1:0]     dbg_data,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done
);

  state_t               state;
  state_t               state_nx;
  logic [REG_IDX_W-1:0] cur;
  logic [REG_IDX_W-1:0] last_q;
  logic                 xfer;
  logic                 load;
  logic                 advance;
  logic                 last_byte;
  logic [7:0]           byte_out;

  assign xfer    = tx_valid & tx_ready;
  assign dbg_sel = cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state != ST_IDLE && abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      if (start) state_nx = ST_CAPTURE;
        ST_CAPTURE:   state_nx = ST_SEND_IDX;
        ST_SEND_IDX:  if (xfer) state_nx = ST_SEND_DATA;
        ST_SEND_DATA: if (xfer && last_byte)
                        state_nx = (cur == last_q) ? ST_DONE : ST_CAPTURE;
        ST_DONE:      state_nx = ST_IDLE;
        default:      state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = 1'b1;
    done     = 1'b0;
    load     = 1'b0;
    advance  = 1'b0;
    case (state)
      ST_IDLE:      busy = 1'b0;
      ST_CAPTURE:   load = 1'b1;
      ST_SEND_IDX: begin
        tx_valid = 1'b1;
        tx_data  = {{(8-REG_IDX_W){1'b0}}, cur};
      end
      ST_SEND_DATA: begin
        tx_valid = 1'b1;
        tx_data  = byte_out;
        advance  = tx_ready & ~abort;
      end
      ST_DONE:      done = 1'b1;
      default:      busy = 1'b0;
    endcase
  end

  // cur wraps modulo 32 naturally, which covers first_reg > last_reg ranges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur    <= '0;
      last_q <= '0;
    end else if (state == ST_IDLE && start) begin
      cur    <= first_reg;
      last_q <= last_reg;
    end else if (state == ST_SEND_DATA && xfer && last_byte && !abort && cur != last_q) begin
      cur <= cur + 1'b1;
    end
  end

  word_byte_serializer #(
    .WIDTH (WIDTH)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (dbg_data),
    .advance   (advance),
    .byte_out  (byte_out),
    .last_byte (last_byte)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_ctrl.sv
`default_nettype none
// tb_regfile_dump_ctrl: randomized and directed checks against a byte-stream reference model.
// Rev 1.0
module tb_regfile_dump_ctrl;

  localparam int WIDTH  = 32;
  localparam int NBYTES = WIDTH / 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [4:0]       first_reg = '0;
  logic [4:0]       last_reg = '0;
  logic             abort = 1'b0;
  logic [4:0]       dbg_sel;
  logic [WIDTH-1:0] dbg_data;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready = 1'b1;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] rf [32];
  logic [7:0]       exp_q [$];
  logic [7:0]       obs [$];
  int               tests = 0;
  int               fails = 0;
  int               cyc = 0;
  int               done_cnt = 0;
  int               done_cyc = 0;
  int               first_valid_cyc = -1;
  int               rmode = 0;
  logic             prev_stall = 1'b0;
  logic [7:0]       prev_data = '0;

  assign dbg_data = rf[dbg_sel];

  regfile_dump_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .abort     (abort),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected stream: for each index in the wrapped range, the index byte then the word MSB first.
  task automatic build_expect(input logic [4:0] f, input logic [4:0] l);
    int n;
    int idx;
    exp_q.delete();
    n = ((int'(l) - int'(f) + 32) % 32) + 1;
    for (int k = 0; k < n; k++) begin
      idx = (int'(f) + k) % 32;
      exp_q.push_back(8'(idx));
      for (int b = NBYTES - 1; b >= 0; b--) exp_q.push_back(8'(rf[idx] >> (8 * b)));
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = (cyc % 3 == 0);
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (reset && tx_valid && tx_ready && !abort) obs.push_back(tx_data);
    if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_stall && tx_valid) check("stall_hold", {24'h0, tx_data}, {24'h0, prev_data});
    prev_stall = reset && tx_valid && !tx_ready && !abort;
    prev_data  = tx_data;
  end

  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                          input bit poke, input bit timing);
    int c0;
    int k;
    int n;
    build_expect(f, l);
    n = exp_q.size() / (NBYTES + 1);
    @(posedge clk);
    #1;
    obs.delete();
    done_cnt = 0;
    first_valid_cyc = -1;
    rmode = mode;
    first_reg = f;
    last_reg = l;
    start = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    first_reg = 5'($urandom);
    last_reg = 5'($urandom);
    k = 0;
    while (done_cnt == 0 && k < 4000) begin
      @(negedge clk);
      #1;
      k++;
      if (poke && k == 5) begin
        start = 1'b1;
        first_reg = ~f;
        last_reg = ~l;
      end
      if (poke && k == 6) start = 1'b0;
    end
    check("done_seen", done_cnt, 1);
    if (timing) begin
      check("idx_latency", first_valid_cyc - c0, 2);
      check("dump_cycles", done_cyc - c0, 1 + n * (2 + NBYTES));
    end
    @(negedge clk);
    #1;
    check("busy_after", busy, 1'b0);
    check("done_one_cycle", done, 1'b0);
    check("byte_count", obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("byte[%0d]", i), (i < obs.size()) ? {24'h0, obs[i]} : 32'h100,
            {24'h0, exp_q[i]});
    rmode = 0;
  endtask

  initial begin
    bit wrote;
    logic [4:0] f;
    logic [4:0] l;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;

    #1;
    check("rst_dbg_sel", dbg_sel, 5'd0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    rf[1] = 32'h12345678;
    run_dump(5'd1, 5'd1, 0, 1'b0, 1'b1);

    rf[0] = 32'h0;
    run_dump(5'd30, 5'd1, 0, 1'b0, 1'b1);

    run_dump(5'd12, 5'd15, 1, 1'b0, 1'b0);

    // Overwrite x5 in the cycle right after its capture; the old value must still go out.
    rf[5] = 32'h0000000A;
    wrote = 1'b0;
    fork
      run_dump(5'd5, 5'd5, 0, 1'b0, 1'b0);
      begin
        for (int k = 0; k < 200 && !wrote; k++) begin
          @(negedge clk);
          if (dbg_sel == 5'd5 && tx_valid && busy) begin
            rf[5] = 32'hFFFFFFFF;
            wrote = 1'b1;
          end
        end
      end
    join
    check("late_write_done", wrote, 1'b1);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      f = 5'($urandom);
      l = 5'($urandom);
      run_dump(f, l, 2, 1'b0, 1'b0);
    end

    run_dump(5'd20, 5'd23, 0, 1'b1, 1'b0);

    // Abort while the second data byte is on the line.
    @(posedge clk);
    #1;
    obs.delete();
    done_cnt = 0;
    first_reg = 5'd2;
    last_reg = 5'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 100 && obs.size() < 2; k++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    #1;
    check("abort_tx_valid", tx_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_bytes", obs.size(), 2);
    run_dump(5'd7, 5'd9, 0, 1'b0, 1'b0);

    // Reset in the middle of a long dump.
    @(posedge clk);
    #1;
    done_cnt = 0;
    first_reg = 5'd0;
    last_reg = 5'd31;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_dbg_sel", dbg_sel, 5'd0);
    check("midrst_tx_data", tx_data, 8'h00);
    check("midrst_tx_valid", tx_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("postrst_busy", busy, 1'b0);
    check("postrst_valid", tx_valid, 1'b0);
    check("postrst_no_done", done_cnt, 0);
    run_dump(5'd31, 5'd0, 2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
